// File: rtl/halfsub_pkg.sv
// halfsub_pkg: cell style encodings and popcount helper shared by the half-subtractor array
package halfsub_pkg;

    localparam int STYLE_GATE     = 0;
    localparam int STYLE_BEHAV    = 1;
    localparam int STYLE_DATAFLOW = 2;
    localparam int MAX_WIDTH      = 64;

    // Counts set bits in the low w bits of a zero-extended vector
    function automatic logic [6:0] popcount(input logic [MAX_WIDTH-1:0] v, input int w);
        logic [6:0] n;
        n = '0;
        for (int k = 0; k < MAX_WIDTH; k++)
            if (k < w) n = n + {6'b0, v[k]};
        return n;
    endfunction

endpackage

// File: rtl/halfsub_cell.sv
// halfsub_cell: 1-bit combinational half subtractor, a-b, in one of three equivalent styles
module halfsub_cell
    import halfsub_pkg::*;
#(
    parameter int STYLE = STYLE_DATAFLOW
) (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);

    generate
        if (STYLE == STYLE_GATE) begin : g_gate
            logic w_na;
            not u_n (w_na, a);
            xor u_x (d, a, b);
            and u_a (bo, w_na, b);
        end else if (STYLE == STYLE_BEHAV) begin : g_behav
            // Truth-table lookup of the two-bit input
            always_comb begin
                case ({a, b})
                    2'b01:   {d, bo} = 2'b11;
                    2'b10:   {d, bo} = 2'b10;
                    default: {d, bo} = 2'b00;
                endcase
            end
        end else if (STYLE == STYLE_DATAFLOW) begin : g_flow
            assign d  = a ^ b;
            assign bo = ~a & b;
        end else begin : g_bad
            $error("halfsub_cell: STYLE must be 0, 1 or 2");
        end
    endgenerate

endmodule

// File: rtl/halfsub_array.sv
// halfsub_array: WIDTH registered half-subtractor lanes with borrow count; HALFSUB_XCHECK_EN adds cross-style checking
module halfsub_array
    import halfsub_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STYLE = STYLE_DATAFLOW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             d,
    output logic [WIDTH-1:0]             bo,
`ifdef HALFSUB_XCHECK_EN
    output logic [$clog2(WIDTH+1)-1:0]   bo_count,
    output logic                         mismatch
`else
    output logic [$clog2(WIDTH+1)-1:0]   bo_count
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("halfsub_array: WIDTH must be in 1..64");
        end
        if (STYLE < STYLE_GATE || STYLE > STYLE_DATAFLOW) begin : g_bad_style
            $error("halfsub_array: STYLE must be 0, 1 or 2");
        end
    endgenerate

    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_bo;
    logic [6:0]       w_cnt;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_bo;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;

`ifdef HALFSUB_XCHECK_EN
    logic [WIDTH-1:0] w_lane_mis;
    logic             r_mis;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic w_d0, w_d1, w_d2, w_b0, w_b1, w_b2;
        halfsub_cell #(.STYLE(STYLE_GATE))     u_c0 (.a(a[i]), .b(b[i]), .d(w_d0), .bo(w_b0));
        halfsub_cell #(.STYLE(STYLE_BEHAV))    u_c1 (.a(a[i]), .b(b[i]), .d(w_d1), .bo(w_b1));
        halfsub_cell #(.STYLE(STYLE_DATAFLOW)) u_c2 (.a(a[i]), .b(b[i]), .d(w_d2), .bo(w_b2));
        assign w_d[i]        = STYLE == STYLE_GATE ? w_d0 : STYLE == STYLE_BEHAV ? w_d1 : w_d2;
        assign w_bo[i]       = STYLE == STYLE_GATE ? w_b0 : STYLE == STYLE_BEHAV ? w_b1 : w_b2;
        assign w_lane_mis[i] = (w_d0 != w_d1) | (w_d0 != w_d2) | (w_b0 != w_b1) | (w_b0 != w_b2);
    end

    // Mismatch flag reflects only the most recent accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_mis <= 1'b0;
        else if (in_valid) r_mis <= |w_lane_mis;
    end

    assign mismatch = r_mis;
`else
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        halfsub_cell #(.STYLE(STYLE)) u_cell (.a(a[i]), .b(b[i]), .d(w_d[i]), .bo(w_bo[i]));
    end
`endif

    assign w_cnt = popcount(MAX_WIDTH'(w_bo), WIDTH);

    // Capture lane results on valid samples; valid bit follows in_valid every edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_d     <= '0;
            r_bo    <= '0;
            r_cnt   <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_d   <= w_d;
                r_bo  <= w_bo;
                r_cnt <= w_cnt[CW-1:0];
            end
        end
    end

    assign out_valid = r_valid;
    assign d         = r_d;
    assign bo        = r_bo;
    assign bo_count  = r_cnt;

endmodule

// File: tb/tb_halfsub_array.sv
// tb_halfsub_array: directed checks of reset, truth table, multi-lane, hold, mid-stream reset and cross-check
module tb_halfsub_array;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       out_valid;
    logic [3:0] d, bo;
    logic [2:0] bo_count;
    logic       mismatch;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic [2:0] v1, d1, bo1, c1, m1;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    halfsub_array #(.WIDTH(4), .STYLE(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .d(d), .bo(bo),
`ifdef HALFSUB_XCHECK_EN
        .bo_count(bo_count), .mismatch(mismatch)
`else
        .bo_count(bo_count)
`endif
    );

`ifndef HALFSUB_XCHECK_EN
    assign mismatch = 1'b0;
    assign m1 = '0;
`endif

    for (genvar s = 0; s < 3; s++) begin : g_w1
        halfsub_array #(.WIDTH(1), .STYLE(s)) u1 (
            .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
            .out_valid(v1[s]), .d(d1[s]), .bo(bo1[s]),
`ifdef HALFSUB_XCHECK_EN
            .bo_count(c1[s]), .mismatch(m1[s])
`else
            .bo_count(c1[s])
`endif
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; a = 4'b0000; b = 4'b1111;
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got %b exp 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_checks++; if (d !== 4'b0000) begin n_fail++; $display("FAIL reset_d got %b exp 0000", d); end
        n_checks++; if (bo !== 4'b0000) begin n_fail++; $display("FAIL reset_bo got %b exp 0000", bo); end
        n_checks++; if (bo_count !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", bo_count); end
        n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch got %b exp 0", mismatch); end
        n_checks++; if (v1 !== 3'b000 || bo1 !== 3'b000) begin n_fail++; $display("FAIL reset_w1 got v=%b bo=%b exp 000", v1, bo1); end
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_truth_table();
        logic [3:0] sa, sb, ed, eb;
        sa = 4'b1100; sb = 4'b0101; ed = 4'b1001; eb = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; a1 = sa[3-k]; b1 = sb[3-k];
            tick();
            n_checks++; if (v1 !== 3'b111) begin n_fail++; $display("FAIL tt_valid[%0d] got %b exp 111", k, v1); end
            n_checks++; if (d1 !== {3{ed[3-k]}}) begin n_fail++; $display("FAIL tt_d[%0d] got %b exp %b", k, d1, {3{ed[3-k]}}); end
            n_checks++; if (bo1 !== {3{eb[3-k]}}) begin n_fail++; $display("FAIL tt_bo[%0d] got %b exp %b", k, bo1, {3{eb[3-k]}}); end
            n_checks++; if (c1 !== {3{eb[3-k]}}) begin n_fail++; $display("FAIL tt_cnt[%0d] got %b exp %b", k, c1, {3{eb[3-k]}}); end
        end
    endtask

    task automatic test_multi_lane();
        logic [3:0] ta [3], tb [3], td [3], tbo [3];
        logic [2:0] tc [3];
        ta = '{4'b1100, 4'b0000, 4'b1011}; tb = '{4'b1010, 4'b1111, 4'b1011};
        td = '{4'b0110, 4'b1111, 4'b0000}; tbo = '{4'b0010, 4'b1111, 4'b0000};
        tc = '{3'd1, 3'd4, 3'd0};
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; a = ta[k]; b = tb[k];
            tick();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ml_valid[%0d] got %b exp 1", k, out_valid); end
            n_checks++; if (d !== td[k]) begin n_fail++; $display("FAIL ml_d[%0d] got %b exp %b", k, d, td[k]); end
            n_checks++; if (bo !== tbo[k]) begin n_fail++; $display("FAIL ml_bo[%0d] got %b exp %b", k, bo, tbo[k]); end
            n_checks++; if (bo_count !== tc[k]) begin n_fail++; $display("FAIL ml_cnt[%0d] got %0d exp %0d", k, bo_count, tc[k]); end
        end
    endtask

    task automatic test_hold();
        in_valid = 1'b1; a = 4'b0101; b = 4'b1110;
        tick();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b0; a = 4'($urandom); b = k == 0 ? 4'bxxxx : 4'($urandom);
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid[%0d] got %b exp 0", k, out_valid); end
            n_checks++; if (d !== 4'b1011) begin n_fail++; $display("FAIL hold_d[%0d] got %b exp 1011", k, d); end
            n_checks++; if (bo !== 4'b1010) begin n_fail++; $display("FAIL hold_bo[%0d] got %b exp 1010", k, bo); end
            n_checks++; if (bo_count !== 3'd2) begin n_fail++; $display("FAIL hold_cnt[%0d] got %0d exp 2", k, bo_count); end
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; a = 4'b1100; b = 4'b1010;
        tick();
        rst = 1'b1; a = 4'b0000; b = 4'b1111;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", out_valid); end
        n_checks++; if (d !== 4'b0000 || bo !== 4'b0000) begin n_fail++; $display("FAIL mid_data got d=%b bo=%b exp 0000", d, bo); end
        n_checks++; if (bo_count !== 3'd0) begin n_fail++; $display("FAIL mid_cnt got %0d exp 0", bo_count); end
        rst = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL post_valid got %b exp 1", out_valid); end
        n_checks++; if (bo !== 4'b1111 || bo_count !== 3'd4) begin n_fail++; $display("FAIL post_data got bo=%b cnt=%0d exp 1111/4", bo, bo_count); end
    endtask

`ifdef HALFSUB_XCHECK_EN
    task automatic test_xcheck();
        for (int k = 0; k < 256; k++) begin
            in_valid = 1'b1; a = 4'(k >> 4); b = 4'(k);
            tick();
            n_checks++; if (mismatch !== 1'b0 || m1 !== 3'b000) begin n_fail++; $display("FAIL xc_sweep[%0d] got %b/%b exp 0", k, mismatch, m1); end
            n_checks++; if (d !== (a ^ b) || bo !== (~a & b)) begin n_fail++; $display("FAIL xc_data[%0d] got %b/%b", k, d, bo); end
        end
        a = 4'b0000; b = 4'b0000;
        force dut.g_lane[0].u_c2.d = 1'b1;
        tick();
        n_checks++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL xc_inject got %b exp 1", mismatch); end
        release dut.g_lane[0].u_c2.d;
        tick();
        n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL xc_clear got %b exp 0", mismatch); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12 rst = 1'b0;
        tick();
        test_reset();
        test_truth_table();
        test_multi_lane();
        test_hold();
        test_reset_midstream();
`ifdef HALFSUB_XCHECK_EN
        test_xcheck();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
